// File: rtl/ddram_readback_check_if.sv
// DDRAM read/write port bundle; master = requester (checker), slave = memory.
interface ddram_readback_check_if;
   logic        DDRAM_BUSY;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic        DDRAM_RD;
   logic [63:0] DDRAM_DOUT;
   logic        DDRAM_DOUT_READY;
   logic        DDRAM_WE;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;

   modport master (
      input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
      output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
   );

   modport slave (
      output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
      input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
   );
endinterface

// File: rtl/ddram_readback_check.sv
// Burst-reads a word region over DDRAM and compares each beat to a pattern; first RD 1 cycle after start,
// done 1 cycle after the last beat; requests held stable while DDRAM_BUSY, one burst outstanding at a time.
module ddram_readback_check #(
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 24
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             start,
   input  logic [28:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic [63:0]      pattern,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_cnt,
   output logic [28:0]      first_err_addr,
   ddram_readback_check_if.master ddram
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [28:0]      cur_addr_q, cur_addr_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [63:0]      pattern_q, pattern_d;
   logic [7:0]       beats_left_q, beats_left_d;
   logic             err_seen_q, err_seen_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [15:0]      err_cnt_q, err_cnt_d;
   logic [28:0]      first_err_q, first_err_d;
   logic             rd_q, rd_d;
   logic [28:0]      addr_q, addr_d;
   logic [7:0]       burstcnt_q, burstcnt_d;

   function automatic logic [7:0] burst_len(input logic [CNT_W-1:0] rem);
      if (rem >= CNT_W'(MAX_BURST)) return 8'(MAX_BURST);
      return 8'(rem);
   endfunction

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      pattern_d    = pattern_q;
      beats_left_d = beats_left_q;
      err_seen_d   = err_seen_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      pass_d       = pass_q;
      err_cnt_d    = err_cnt_q;
      first_err_d  = first_err_q;
      rd_d         = rd_q;
      addr_d       = addr_q;
      burstcnt_d   = burstcnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_addr_d  = base_addr;
               remaining_d = word_count;
               pattern_d   = pattern;
               err_cnt_d   = 16'd0;
               first_err_d = 29'd0;
               err_seen_d  = 1'b0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               if (word_count == '0) begin
                  state_d = S_FIN;
               end else begin
                  state_d    = S_REQ;
                  rd_d       = 1'b1;
                  addr_d     = base_addr;
                  burstcnt_d = burst_len(word_count);
               end
            end
         end
         S_REQ: begin
            if (!ddram.DDRAM_BUSY) begin
               rd_d         = 1'b0;
               beats_left_d = burstcnt_q;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ddram.DDRAM_DOUT_READY) begin
               cur_addr_d   = cur_addr_q + 29'd1;
               remaining_d  = remaining_q - CNT_W'(1);
               beats_left_d = beats_left_q - 8'd1;
               if (ddram.DDRAM_DOUT != pattern_q) begin
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  if (!err_seen_q) begin
                     first_err_d = cur_addr_q;
                     err_seen_d  = 1'b1;
                  end
               end
               if (beats_left_q == 8'd1) begin
                  if (remaining_d != '0) begin
                     state_d    = S_REQ;
                     rd_d       = 1'b1;
                     addr_d     = cur_addr_d;
                     burstcnt_d = burst_len(remaining_d);
                  end else begin
                     state_d = S_FIN;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     pass_d  = ~err_seen_d;
                  end
               end
            end
         end
         S_FIN: begin
            // An empty region enters FIN with done low and spends one extra cycle raising it.
            if (done_q) begin
               state_d = S_IDLE;
            end else begin
               done_d = 1'b1;
               busy_d = 1'b0;
               pass_d = ~err_seen_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         pattern_q    <= '0;
         beats_left_q <= '0;
         err_seen_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         first_err_q  <= '0;
         rd_q         <= 1'b0;
         addr_q       <= '0;
         burstcnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         pattern_q    <= pattern_d;
         beats_left_q <= beats_left_d;
         err_seen_q   <= err_seen_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_cnt_q    <= err_cnt_d;
         first_err_q  <= first_err_d;
         rd_q         <= rd_d;
         addr_q       <= addr_d;
         burstcnt_q   <= burstcnt_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_q;

   assign ddram.DDRAM_RD       = rd_q;
   assign ddram.DDRAM_ADDR     = addr_q;
   assign ddram.DDRAM_BURSTCNT = burstcnt_q;
   assign ddram.DDRAM_WE       = 1'b0;
   assign ddram.DDRAM_DIN      = 64'd0;
   assign ddram.DDRAM_BE       = 8'hFF;

endmodule

// File: tb/tb_ddram_readback_check.sv
// Bench for ddram_readback_check: memory responder with optional stalls/gaps, vector table,
// hand sequences for stall/reset/restart, and randomized regions checked against a region-level model.
module tb_ddram_readback_check;
   localparam int MB = 8;
   localparam int CW = 24;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [28:0]   base_addr = '0;
   logic [CW-1:0] word_count = '0;
   logic [63:0]   pattern = '0;
   logic          busy, done, pass;
   logic [15:0]   err_cnt;
   logic [28:0]   first_err_addr;

   ddram_readback_check_if ddr();

   ddram_readback_check #(.MAX_BURST(MB), .CNT_W(CW)) dut (
      .clk_sys(clk_sys), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .pattern(pattern), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr), .ddram(ddr)
   );

   initial forever #5 clk_sys = ~clk_sys;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, first_rd_cyc = -1, last_beat_cyc = 0;
   int beats_sent = 0, lat_cnt = 0, stall_left = 0, stab_viol = 0;
   bit rand_busy = 0, rand_gaps = 0;
   logic [28:0] req_addr[$];
   int          req_len[$];
   logic [28:0] beat_q[$];
   logic [28:0] exp_addr[$];
   int          exp_len[$];
   logic [63:0] err_map [logic [28:0]];
   logic [63:0] fill_val = '0;
   logic        prev_rd = 0, prev_busy = 0;
   logic [28:0] prev_addr = '0;
   logic [7:0]  prev_len = '0;

   function automatic logic [63:0] mem_data(input logic [28:0] a);
      if (err_map.exists(a)) return err_map[a];
      return fill_val;
   endfunction

   // Memory responder and monitors; inputs change only on the falling edge.
   initial begin
      logic [28:0] a;
      ddr.DDRAM_BUSY = 1'b0;
      ddr.DDRAM_DOUT_READY = 1'b0;
      ddr.DDRAM_DOUT = '0;
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (ddr.DDRAM_RD && first_rd_cyc < 0) first_rd_cyc = cyc;
         if (prev_rd && prev_busy &&
             !(ddr.DDRAM_RD && ddr.DDRAM_ADDR == prev_addr && ddr.DDRAM_BURSTCNT == prev_len))
            stab_viol++;
         if (lat_cnt > 0) begin
            lat_cnt--;
            ddr.DDRAM_DOUT_READY = 1'b0;
            ddr.DDRAM_DOUT = {$urandom, $urandom};
         end else if (beat_q.size() > 0 && (!rand_gaps || $urandom_range(0, 2) != 0)) begin
            a = beat_q.pop_front();
            ddr.DDRAM_DOUT_READY = 1'b1;
            ddr.DDRAM_DOUT = mem_data(a);
            beats_sent++;
            last_beat_cyc = cyc;
         end else begin
            ddr.DDRAM_DOUT_READY = 1'b0;
            ddr.DDRAM_DOUT = {$urandom, $urandom};
         end
         if (stall_left > 0 && ddr.DDRAM_RD) begin
            ddr.DDRAM_BUSY = 1'b1;
            stall_left--;
         end else if (rand_busy) ddr.DDRAM_BUSY = ($urandom_range(0, 3) == 0);
         else ddr.DDRAM_BUSY = 1'b0;
         if (ddr.DDRAM_RD && !ddr.DDRAM_BUSY && !reset) begin
            req_addr.push_back(ddr.DDRAM_ADDR);
            req_len.push_back(int'(ddr.DDRAM_BURSTCNT));
            for (int j = 0; j < int'(ddr.DDRAM_BURSTCNT); j++) beat_q.push_back(ddr.DDRAM_ADDR + 29'(j));
            lat_cnt = $urandom_range(0, 2);
         end
         prev_rd = ddr.DDRAM_RD; prev_busy = ddr.DDRAM_BUSY;
         prev_addr = ddr.DDRAM_ADDR; prev_len = ddr.DDRAM_BURSTCNT;
      end
   end

   task automatic tick();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Region-level reference: request split and mismatch summary from plain word arithmetic.
   task automatic model(input logic [28:0] b, input int n, input logic [63:0] pat,
                        output logic ep, output logic [15:0] ec, output logic [28:0] ef);
      int cnt = 0;
      logic [28:0] a;
      ef = '0;
      exp_addr.delete(); exp_len.delete();
      for (int off = 0; off < n; off += MB) begin
         exp_addr.push_back(b + 29'(off));
         exp_len.push_back((n - off < MB) ? n - off : MB);
      end
      for (int i = 0; i < n; i++) begin
         a = b + 29'(i);
         if (mem_data(a) != pat) begin
            if (cnt == 0) ef = a;
            cnt++;
         end
      end
      ep = (cnt == 0);
      ec = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic run_check(input string nm, input logic [28:0] b, input int n, input logic [63:0] pat,
                            input logic ep, input logic [15:0] ec, input logic [28:0] ef,
                            input int extra_start);
      logic mp; logic [15:0] mc; logic [28:0] mf;
      int start_cyc;
      bit got, bad;
      model(b, n, pat, mp, mc, mf);
      req_addr.delete(); req_len.delete();
      done_cnt = 0; first_rd_cyc = -1; stab_viol = 0;
      base_addr = b; word_count = CW'(n); pattern = pat; start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      got = 0;
      for (int i = 0; i < n * 8 + 100; i++) begin
         if (i == 0) chk({nm, ".busy_hi"}, 64'(busy), 64'd1);
         if (done_cnt > 0) begin got = 1; break; end
         if (i == extra_start) begin
            base_addr = 29'h300; word_count = CW'(3); pattern = '1; start = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      chk({nm, ".done_seen"}, 64'(got), 64'd1);
      if (!got) begin do_reset(); return; end
      chk({nm, ".pass"}, 64'(pass), 64'(ep));
      chk({nm, ".err_cnt"}, 64'(err_cnt), 64'(ec));
      chk({nm, ".first_err"}, 64'(first_err_addr), 64'(ef));
      chk({nm, ".busy_lo"}, 64'(busy), 64'd0);
      chk({nm, ".done_lat"}, 64'(done_cyc), 64'((n == 0) ? start_cyc + 2 : last_beat_cyc + 1));
      chk({nm, ".first_rd"}, 64'(first_rd_cyc), 64'((n == 0) ? -1 : start_cyc + 1));
      repeat (3) tick();
      chk({nm, ".done_once"}, 64'(done_cnt), 64'd1);
      bad = (req_addr.size() != exp_addr.size());
      for (int i = 0; i < req_addr.size() && !bad; i++)
         if (req_addr[i] != exp_addr[i] || req_len[i] != exp_len[i]) bad = 1;
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL %s.reqs: got %0d requests (first %0h/%0d) expected %0d (first %0h/%0d)", nm,
                  req_addr.size(), (req_addr.size() > 0) ? req_addr[0] : 29'h0,
                  (req_len.size() > 0) ? req_len[0] : 0, exp_addr.size(),
                  (exp_addr.size() > 0) ? exp_addr[0] : 29'h0, (exp_len.size() > 0) ? exp_len[0] : 0);
      end
   endtask

   typedef struct {
      logic [28:0] base;
      int          count;
      int          n_err;
      logic [28:0] ea;
      logic [28:0] eb;
      logic        exp_pass;
      logic [15:0] exp_cnt;
      logic [28:0] exp_first;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic ep; logic [15:0] ec; logic [28:0] ef;
      logic [28:0] b;
      int n, nerr, b0;
      logic [63:0] pat;
      bit got;

      vecs[0] = '{29'h100, 20, 0, 29'h0, 29'h0, 1'b1, 16'd0, 29'h0};
      vecs[1] = '{29'h100, 20, 1, 29'h10B, 29'h0, 1'b0, 16'd1, 29'h10B};
      vecs[2] = '{29'h100, 20, 2, 29'h105, 29'h112, 1'b0, 16'd2, 29'h105};
      vecs[3] = '{29'h100, 0, 0, 29'h0, 29'h0, 1'b1, 16'd0, 29'h0};
      vecs[4] = '{29'h1FFFFFFE, 4, 0, 29'h0, 29'h0, 1'b1, 16'd0, 29'h0};
      vecs[5] = '{29'h1FFFFFFE, 4, 2, 29'h1, 29'h1FFFFFFF, 1'b0, 16'd2, 29'h1FFFFFFF};
      vecs[6] = '{29'h55, 1, 1, 29'h55, 29'h0, 1'b0, 16'd1, 29'h55};
      vecs[7] = '{29'h200, 8, 0, 29'h0, 29'h0, 1'b1, 16'd0, 29'h0};
      vecs[8] = '{29'h200, 9, 1, 29'h208, 29'h0, 1'b0, 16'd1, 29'h208};

      repeat (3) tick();
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.pass", 64'(pass), 64'd0);
      chk("rst.err_cnt", 64'(err_cnt), 64'd0);
      chk("rst.first_err", 64'(first_err_addr), 64'd0);
      chk("rst.rd", 64'(ddr.DDRAM_RD), 64'd0);
      chk("rst.addr_len", {27'd0, ddr.DDRAM_ADDR, ddr.DDRAM_BURSTCNT}, 64'd0);
      chk("rst.tieoffs", {ddr.DDRAM_DIN[55:0], ddr.DDRAM_WE, ddr.DDRAM_BE[6:0]}, 64'h7F);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 9; v++) begin
         err_map.delete();
         fill_val = '0;
         if (vecs[v].n_err > 0) err_map[vecs[v].ea] = 64'h1;
         if (vecs[v].n_err > 1) err_map[vecs[v].eb] = 64'h8000_0000_0000_0000;
         run_check($sformatf("vec%0d", v), vecs[v].base, vecs[v].count, 64'd0,
                   vecs[v].exp_pass, vecs[v].exp_cnt, vecs[v].exp_first, -1);
      end

      // Request held under a 5-cycle stall must not move.
      err_map.delete();
      stall_left = 5;
      run_check("stall", 29'h100, 20, 64'd0, 1'b1, 16'd0, 29'h0, -1);
      chk("stall.stable", 64'(stab_viol), 64'd0);

      // A second start mid-run must be ignored.
      run_check("restart", 29'h100, 20, 64'd0, 1'b1, 16'd0, 29'h0, 6);

      // Reset during the second burst, with late beats still in flight.
      err_map.delete();
      err_map[29'h101] = 64'h1;
      err_map[29'h10E] = 64'h1;
      err_map[29'h10F] = 64'h1;
      b0 = beats_sent;
      base_addr = 29'h100; word_count = CW'(20); pattern = '0; start = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 300; i++) begin
         if (beats_sent >= b0 + 10) begin got = 1; break; end
         tick();
      end
      chk("rst_mid.reached", 64'(got), 64'd1);
      chk("rst_mid.err_before", 64'(err_cnt), 64'd1);
      reset = 1'b1;
      tick();
      chk("rst_mid.busy", 64'(busy), 64'd0);
      chk("rst_mid.err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_mid.first_err", 64'(first_err_addr), 64'd0);
      chk("rst_mid.pass_done", {62'd0, pass, done}, 64'd0);
      chk("rst_mid.ddram", {26'd0, ddr.DDRAM_RD, ddr.DDRAM_ADDR, ddr.DDRAM_BURSTCNT}, 64'd0);
      chk("rst_mid.leftover", 64'(beat_q.size() > 0), 64'd1);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 100 && beat_q.size() > 0; i++) tick();
      repeat (3) tick();
      chk("rst_mid.late_err", 64'(err_cnt), 64'd0);
      chk("rst_mid.late_first", 64'(first_err_addr), 64'd0);
      chk("rst_mid.late_busy_done", {62'd0, busy, 1'(done_cnt != 0)}, 64'd0);
      err_map.delete();
      run_check("rst_mid.clean", 29'h100, 20, 64'd0, 1'b1, 16'd0, 29'h0, -1);

      // Randomized regions, patterns, stalls and beat gaps.
      rand_busy = 1;
      rand_gaps = 1;
      for (int r = 0; r < 14; r++) begin
         b = 29'($urandom);
         if ($urandom_range(0, 2) == 0) b = 29'h1FFFFFF0 + 29'($urandom_range(0, 15));
         n = $urandom_range(0, 40);
         pat = {$urandom, $urandom};
         fill_val = pat;
         err_map.delete();
         nerr = (n > 0) ? $urandom_range(0, 3) : 0;
         for (int k = 0; k < nerr; k++)
            err_map[b + 29'($urandom_range(0, n - 1))] = pat ^ {32'h0, 32'($urandom) | 32'h1};
         model(b, n, pat, ep, ec, ef);
         run_check($sformatf("rnd%0d", r), b, n, pat, ep, ec, ef, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
